// File: rtl/adder_16_pkg.sv
// Shared width constant and result type for the 16-bit ripple adder.
// Imported by the adder top and its bench.
package adder_16_pkg;
    localparam int WIDTH = 16;
    typedef logic [WIDTH-1:0] sum_t;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// The ripple chain in adder_16 is built from these cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

// File: rtl/adder_16.sv
// Ripple-carry adder with combinational and registered sum/carry.
// Define ADDER_16_OVF_EN to add signed-overflow outputs ovf/ovf_r.
module adder_16 #(
    parameter int WIDTH = adder_16_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_r,
    output logic             cout_r
`ifdef ADDER_16_OVF_EN
    ,
    output logic             ovf,
    output logic             ovf_r
`endif
);
    import adder_16_pkg::*;

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a  (in1[i]),
            .b  (in2[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            sum_r  <= sum;
            cout_r <= cout;
        end
    end

`ifdef ADDER_16_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_r <= 1'b0;
        else     ovf_r <= ovf;
    end
`endif
endmodule

// File: tb/tb_adder_16.sv
// Directed self-checking bench for adder_16.
// Covers combinational vectors, register timing and async reset.
module tb_adder_16;
    import adder_16_pkg::*;

    logic clk = 1'b0;
    logic rst;
    sum_t in1, in2;
    logic cin;
    sum_t sum, sum_r;
    logic cout, cout_r;
`ifdef ADDER_16_OVF_EN
    logic ovf, ovf_r;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    adder_16 dut (
        .clk    (clk),
        .rst    (rst),
        .in1    (in1),
        .in2    (in2),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .sum_r  (sum_r),
        .cout_r (cout_r)
`ifdef ADDER_16_OVF_EN
        ,
        .ovf    (ovf),
        .ovf_r  (ovf_r)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        n_cmp++;
        if (sum_r !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_sum_r: got %h want 0000", sum_r);
        end
        n_cmp++;
        if (cout_r !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_cout_r: got %b want 0", cout_r);
        end
    endtask

    task automatic test_comb;
        sum_t a [10] = '{16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF,
                         16'hFFFF, 16'hFFFF, 16'hAAAA, 16'hAAAA,
                         16'hDA83, 16'hDA83};
        sum_t b [10] = '{16'h0000, 16'h0001, 16'h0001, 16'h0001,
                         16'hFFFF, 16'hFFFF, 16'h5555, 16'h5555,
                         16'h43AF, 16'h43AF};
        logic ci [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                          1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        sum_t es [10] = '{16'h0000, 16'h0003, 16'h0000, 16'h0001,
                          16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h0000,
                          16'h1E32, 16'h1E33};
        logic ec [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            in1 = a[i];
            in2 = b[i];
            cin = ci[i];
            #1;
            n_cmp++;
            if (sum !== es[i]) begin
                n_bad++;
                $display("FAIL comb_sum[%0d]: got %h want %h", i, sum, es[i]);
            end
            n_cmp++;
            if (cout !== ec[i]) begin
                n_bad++;
                $display("FAIL comb_cout[%0d]: got %b want %b", i, cout, ec[i]);
            end
        end
    endtask

    task automatic test_registered;
        @(negedge clk);
        in1 = 16'hDA83; in2 = 16'h43AF; cin = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (sum_r !== 16'h1E33 || cout_r !== 1'b1) begin
            n_bad++;
            $display("FAIL reg_load: got %b/%h want 1/1e33", cout_r, sum_r);
        end
        @(negedge clk);
        in1 = 16'hAAAA; in2 = 16'h5555; cin = 1'b0;
        #1;
        n_cmp++;
        if (sum_r !== 16'h1E33 || cout_r !== 1'b1) begin
            n_bad++;
            $display("FAIL reg_hold: got %b/%h want 1/1e33", cout_r, sum_r);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (sum_r !== 16'hFFFF || cout_r !== 1'b0) begin
            n_bad++;
            $display("FAIL reg_next: got %b/%h want 0/ffff", cout_r, sum_r);
        end
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (sum_r !== 16'h0000 || cout_r !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst: got %b/%h want 0/0000", cout_r, sum_r);
        end
        n_cmp++;
        if (sum !== 16'hFFFF || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_comb: got %b/%h want 0/ffff", cout, sum);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (sum_r !== 16'h0000 || cout_r !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_hold: got %b/%h want 0/0000", cout_r, sum_r);
        end
        @(negedge clk);
        rst = 1'b0;
        in1 = 16'hFFFF; in2 = 16'h0001; cin = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (sum_r !== 16'h0001 || cout_r !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_release: got %b/%h want 1/0001", cout_r, sum_r);
        end
    endtask

`ifdef ADDER_16_OVF_EN
    task automatic test_ovf;
        @(negedge clk);
        in1 = 16'h7FFF; in2 = 16'h0001; cin = 1'b0;
        #1;
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_pos: got %b want 1", ovf);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ovf_r !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_r_pos: got %b want 1", ovf_r);
        end
        @(negedge clk);
        in1 = 16'hFFFF; in2 = 16'h0001; cin = 1'b0;
        #1;
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_wrap: got %b want 0", ovf);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ovf_r !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_r_wrap: got %b want 0", ovf_r);
        end
    endtask
`else
    task automatic test_ovf;
    endtask
`endif

    initial begin
        rst = 1'b1;
        in1 = 16'h0000; in2 = 16'h0000; cin = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_comb();
        test_registered();
        test_reset_midstream();
        test_ovf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
